// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : instruction-type codes, commit FSM states, writeback classifier
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [3:0] ITYPE_ALU     = 4'd0;
  localparam logic [3:0] ITYPE_ALU_IMM = 4'd1;
  localparam logic [3:0] ITYPE_LOAD    = 4'd2;
  localparam logic [3:0] ITYPE_STORE   = 4'd3;
  localparam logic [3:0] ITYPE_BRANCH  = 4'd4;
  localparam logic [3:0] ITYPE_JAL     = 4'd5;
  localparam logic [3:0] ITYPE_JALR    = 4'd6;
  localparam logic [3:0] ITYPE_SYSTEM  = 4'd7;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ST_WAIT = 2'd1,
    FLUSH   = 2'd2
  } commit_state_e;

  function automatic logic is_writeback(input logic [3:0] itype);
    return (itype == ITYPE_ALU)  || (itype == ITYPE_ALU_IMM) ||
           (itype == ITYPE_LOAD) || (itype == ITYPE_JAL)     ||
           (itype == ITYPE_JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_ctrl_if.sv
// ============================================================================
// commit_ctrl_if : ROB head / regfile / LSU / fetch-redirect signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface commit_ctrl_if #(
  parameter int XLEN = 32
);
  logic            head_valid;
  logic            head_done;
  logic            head_exc;
  logic [3:0]      head_itype;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_result;
  logic            rob_pop;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            st_commit_req;
  logic            st_commit_ack;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;

  // master: the commit controller
  modport master (
    input  head_valid, head_done, head_exc, head_itype, head_rd, head_result,
    input  st_commit_ack,
    output rob_pop, rf_we, rf_waddr, rf_wdata, st_commit_req, flush, redirect_pc
  );

  // slave: ROB, regfile, LSU and fetch as seen together
  modport slave (
    output head_valid, head_done, head_exc, head_itype, head_rd, head_result,
    output st_commit_ack,
    input  rob_pop, rf_we, rf_waddr, rf_wdata, st_commit_req, flush, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/commit_ctrl.sv
// ============================================================================
// commit_ctrl : in-order single-retire sequencer from ROB head to regfile/LSU
// Rev 1.0
// ============================================================================
`default_nettype none

module commit_ctrl
  import riscv_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  commit_ctrl_if.master         bus,
  output logic [CNT_W-1:0]      retire_count,
  output logic                  busy
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  commit_state_e   state_q, state_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            st_req_q, st_req_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;
  logic            rob_pop;
  logic            ready;

  assign ready = bus.head_valid & bus.head_done;

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    st_req_d       = st_req_q;
    flush_d        = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    retire_count_d = retire_count_q;
    rob_pop        = 1'b0;

    case (state_q)
      RUN: begin
        if (ready && bus.head_exc) begin
          // Exceptions do not pop: the flush discards the whole ROB
          flush_d       = 1'b1;
          redirect_pc_d = XLEN'(TRAP_VEC);
          flush_cnt_d   = FC_W'(FLUSH_CYCLES - 1);
          state_d       = FLUSH;
        end else if (ready && bus.head_itype == ITYPE_STORE) begin
          st_req_d = 1'b1;
          state_d  = ST_WAIT;
        end else if (ready) begin
          rob_pop        = 1'b1;
          retire_count_d = retire_count_q + CNT_W'(1);
          if (is_writeback(bus.head_itype) && bus.head_rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.head_rd;
            rf_wdata_d = bus.head_result;
          end
        end
      end
      ST_WAIT: begin
        if (bus.st_commit_ack) begin
          rob_pop        = 1'b1;
          st_req_d       = 1'b0;
          retire_count_d = retire_count_q + CNT_W'(1);
          state_d        = RUN;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = RUN;
        else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      flush_cnt_q    <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      st_req_q       <= 1'b0;
      flush_q        <= 1'b0;
      redirect_pc_q  <= '0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      st_req_q       <= st_req_d;
      flush_q        <= flush_d;
      redirect_pc_q  <= redirect_pc_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign bus.rob_pop       = rob_pop;
  assign bus.rf_we         = rf_we_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.st_commit_req = st_req_q;
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign retire_count      = retire_count_q;
  assign busy              = (state_q != RUN);

endmodule

`default_nettype wire

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- In-order retirement sequencer between the Reorder Buffer head and the architectural integer register file.
- Decides each cycle whether the ROB head may retire, then:
  - drives the regfile write port for writeback types;
  - performs a request/acknowledge store-commit handshake with the LSU for stores;
  - raises a pipeline flush with trap redirect when the head carries an exception.
- Retires at most one instruction per cycle.

Parameters:
- XLEN, 32, datapath width.
- TRAP_VEC, 32'h0000_0100, redirect PC on exception.
- FLUSH_CYCLES, 2, cycles spent in FLUSH before retirement resumes (>=1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- head_valid  in  1  ROB head entry occupied
- head_done  in  1  ROB head result is complete
- head_exc  in  1  ROB head raised an exception
- head_itype  in  4  instruction type code (ITYPE_* encoding)
- head_rd  in  5  destination architectural register
- head_result  in  XLEN  result value
- rob_pop  out  1  combinational; ROB advances head at this clock edge
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  5  regfile write address (registered)
- rf_wdata  out  XLEN  regfile write data (registered)
- st_commit_req  out  1  store-commit request to LSU (registered, level)
- st_commit_ack  in  1  LSU accepted store, single-cycle pulse
- flush  out  1  pipeline flush pulse (registered)
- redirect_pc  out  XLEN  fetch redirect target, valid with flush
- retire_count  out  CNT_W  retired-instruction counter
- busy  out  1  high whenever state != RUN

Behaviour:
- Reset is asynchronous: all registered outputs 0, redirect_pc 0, retire_count 0, state RUN.
- Reset mid-handshake drops st_commit_req immediately; no pop is issued.
- Let `ready = head_valid & head_done`.
- Writeback types (`wb`): ALU, ALU_IMM, LOAD, JAL, JALR.
- Store type: STORE. All other types (BRANCH, etc.) retire with no side effect.
- State RUN:
  - `ready & head_exc`:
    - next cycle flush=1 for exactly one cycle, redirect_pc=TRAP_VEC;
    - rob_pop=0 (the flush clears the ROB);
    - go to FLUSH with counter=FLUSH_CYCLES-1.
  - `ready & !head_exc & STORE`:
    - rob_pop=0;
    - next cycle st_commit_req=1;
    - go to ST_WAIT.
  - `ready & !head_exc & other types`:
    - rob_pop=1 this cycle, retire_count+1 next edge.
    - For `wb` types, next cycle rf_we=1, rf_waddr=head_rd, rf_wdata=head_result.
    - When head_rd==0, rf_we=0 (x0 is never written); the pop and count still occur.
  - Otherwise: rob_pop=0, rf_we=0.
- State ST_WAIT:
  - st_commit_req held high until st_commit_ack.
  - On ack: rob_pop=1 this cycle, st_commit_req=0 next edge, retire_count+1, return to RUN.
  - An ack arriving in the same cycle the request first rises is legal.
  - head_* inputs are stable while in ST_WAIT (ROB head unchanged).
- State FLUSH:
  - rob_pop=0, rf_we=0.
  - Counter decrements each cycle; at 0, return to RUN.
  - head_* ignored.
- Ordering and pacing:
  - rf_we is one cycle after the pop; it is a pulse unless back-to-back retirements occur.
  - Back-to-back retirement at 1/cycle is sustained in RUN.
- st_commit_ack outside ST_WAIT is ignored. Nothing is popped and no counter changes.
- retire_count wraps modulo 2^CNT_W. Exceptions do not count.
- Priority: exception > store > normal retire. Only the head is examined.

Decomposition:
- Shared package `riscv_pkg`:
  - ITYPE_* instruction-type constants (4-bit);
  - commit_state_e enum {RUN, ST_WAIT, FLUSH};
  - an `is_writeback(itype)` function.
- No sub-module needed; the FSM and write-port registers live in one module.
- The regfile remains a separate block fed by rf_*.

Test Plan:
1. ALU retire: head_valid=done=1, itype=ALU, rd=5, result=0x1234 -> rob_pop=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; retire_count=1.
2. x0 and branch: ALU rd=0, then BRANCH -> two pops over two cycles, rf_we stays 0, retire_count=2.
3. Store handshake: STORE head; ack withheld 3 cycles -> st_commit_req high 3 cycles, busy=1, no pop; ack pulse -> rob_pop=1 that cycle, req low next edge, count+1.
4. Exception: LOAD with head_exc=1 -> no pop; flush=1 for one cycle, redirect_pc=0x100; busy for FLUSH_CYCLES=2 cycles; a ready ALU head during FLUSH is ignored and is popped on the first RUN cycle.
5. Throughput: 4 consecutive ready ALU heads rd=1..4 -> rob_pop high 4 consecutive cycles; rf writes to 1..4 on the following 4 cycles.
6. Reset mid-store: assert rst_n=0 while in ST_WAIT -> st_commit_req=0 asynchronously; after release state=RUN, retire_count=0; a stray ack is ignored.
